// File: rtl/maxpool_unit.sv
// Per-channel signed max pooling over WIN accepted beats, with a bypass mode and a single output register.
// Optional macro MAXPOOL_RELU_EN clamps negative output channels to zero in both modes.
module maxpool_unit #(
  parameter int DATA_W = 8,
  parameter int CH     = 4,
  parameter int WIN    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 maxpool_en,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CH*DATA_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 busy
);

  localparam int CNT_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

  logic [CNT_W-1:0]      win_cnt;
  logic [CH*DATA_W-1:0]  acc;
  logic [CH*DATA_W-1:0]  merged;
  logic [CH*DATA_W-1:0]  result;
  logic [CH*DATA_W-1:0]  bypass_val;
  logic                  accept;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  // Strict greater-than so that ties keep the accumulator value.
  function automatic logic [DATA_W-1:0] smax(input logic [DATA_W-1:0] a_v,
                                             input logic [DATA_W-1:0] d_v);
    return ($signed(d_v) > $signed(a_v)) ? d_v : a_v;
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign busy     = (win_cnt != '0);

  // The first beat of a window seeds the accumulator directly (no zero seeding).
  always_comb begin
    merged     = '0;
    result     = '0;
    bypass_val = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      merged[c*DATA_W +: DATA_W] = (win_cnt == '0) ? in_data[c*DATA_W +: DATA_W]
                                 : smax(acc[c*DATA_W +: DATA_W], in_data[c*DATA_W +: DATA_W]);
      result[c*DATA_W +: DATA_W]     = relu(merged[c*DATA_W +: DATA_W]);
      bypass_val[c*DATA_W +: DATA_W] = relu(in_data[c*DATA_W +: DATA_W]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      win_cnt   <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      if (flush) begin
        win_cnt <= '0;
      end else if (!maxpool_en) begin
        win_cnt <= '0;
        if (accept) begin
          out_data  <= bypass_val;
          out_valid <= 1'b1;
        end
      end else if (accept) begin
        if (win_cnt == LAST) begin
          out_data  <= result;
          out_valid <= 1'b1;
          win_cnt   <= '0;
        end else begin
          acc     <= merged;
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maxpool_unit.sv
// Self-checking bench for maxpool_unit: directed vectors plus a randomized scoreboard run.
module tb_maxpool_unit;

  localparam int DW  = 8;
  localparam int CH  = 4;
  localparam int WIN = 4;
  localparam int BW  = CH * DW;

  logic          clk = 1'b0;
  logic          rst, maxpool_en, flush, in_valid, out_ready;
  logic          in_ready, out_valid, busy;
  logic [BW-1:0] in_data, out_data;

  int checks   = 0;
  int failures = 0;

  logic [BW-1:0] bt [WIN];

  maxpool_unit #(.DATA_W(DW), .CH(CH), .WIN(WIN)) dut (
    .clk(clk), .rst(rst), .maxpool_en(maxpool_en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int relu_i(input int v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [BW-1:0] expect_max();
    logic [BW-1:0] r;
    int m, v;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      m = $signed(bt[0][c*DW +: DW]);
      for (int k = 1; k < WIN; k++) begin
        v = $signed(bt[k][c*DW +: DW]);
        if (v > m) m = v;
      end
      r[c*DW +: DW] = DW'(relu_i(m));
    end
    return r;
  endfunction

  function automatic logic [BW-1:0] expect_bypass(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      r[c*DW +: DW] = DW'(relu_i($signed(d[c*DW +: DW])));
    return r;
  endfunction

  function automatic logic [BW-1:0] rand_beat();
    logic [BW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  function automatic logic [BW-1:0] pack_all(input int v);
    logic [BW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = DW'(v);
    return r;
  endfunction

  task automatic send(input logic [BW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_window(input string name);
    logic [BW-1:0] exp_v;
    exp_v = expect_max();
    for (int k = 0; k < WIN; k++) begin
      send(bt[k]);
      if (k < WIN - 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy_mid beat=%0d got=%b want=1", name, k, busy);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_v || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s result got valid=%b data=%h busy=%b want valid=1 data=%h busy=0",
               name, out_valid, out_data, busy, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; maxpool_en = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset got valid=%b busy=%b data=%h ready=%b want 0 0 0 1",
               out_valid, busy, out_data, in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_spec_vectors();
    logic [DW-1:0] ch0;
    maxpool_en = 1'b1;
    for (int k = 0; k < WIN; k++) bt[k] = rand_beat();
    bt[0][DW-1:0] = DW'(-5); bt[1][DW-1:0] = DW'(-3);
    bt[2][DW-1:0] = DW'(-7); bt[3][DW-1:0] = DW'(-9);
    do_window("neg_window");
    ch0 = out_data[DW-1:0];
    checks++;
`ifdef MAXPOOL_RELU_EN
    if (ch0 !== 8'h00) begin
      failures++; $display("FAIL neg_window_ch0 got=%h want=00", ch0);
    end
`else
    if (ch0 !== 8'hFD) begin
      failures++; $display("FAIL neg_window_ch0 got=%h want=fd", ch0);
    end
`endif
    bt[0] = pack_all(8'h7F); bt[1] = pack_all(8'h80);
    bt[2] = pack_all(8'h01); bt[3] = pack_all(8'h00);
    do_window("signed_cmp");
    checks++;
    if (out_data !== pack_all(8'h7F)) begin
      failures++; $display("FAIL signed_cmp_const got=%h want=%h", out_data, pack_all(8'h7F));
    end
  endtask

  task automatic test_random_windows();
    maxpool_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < WIN; k++) bt[k] = rand_beat();
      do_window("rand_window");
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] held, fifth;
    maxpool_en = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < WIN; k++) bt[k] = rand_beat();
    held = expect_max();
    for (int k = 0; k < WIN; k++) send(bt[k]);
    checks++;
    if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_hold got valid=%b data=%h ready=%b want 1 %h 0",
               out_valid, out_data, in_ready, held);
    end
    fifth = rand_beat();
    in_valid = 1'b1; in_data = fifth;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== held || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall got valid=%b data=%h busy=%b want 1 %h 0",
               out_valid, out_data, busy, held);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready got=%b want=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain_accept got busy=%b valid=%b want 1 0", busy, out_valid);
    end
    bt[0] = fifth;
    for (int k = 1; k < WIN; k++) bt[k] = rand_beat();
    for (int k = 1; k < WIN; k++) send(bt[k]);
    checks++;
    if (out_valid !== 1'b1 || out_data !== expect_max()) begin
      failures++;
      $display("FAIL bp_window got valid=%b data=%h want 1 %h", out_valid, out_data, expect_max());
    end
  endtask

  task automatic test_flush();
    maxpool_en = 1'b1;
    out_ready = 1'b1;
    send(pack_all(100));
    send(pack_all(90));
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL flush_pre busy got=%b want=1", busy);
    end
    flush = 1'b1; in_valid = 1'b1; in_data = pack_all(120);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_clear got busy=%b valid=%b want 0 0", busy, out_valid);
    end
    for (int k = 0; k < WIN; k++) bt[k] = pack_all(k + 1);
    do_window("flush_window");
  endtask

  task automatic test_bypass();
    logic [BW-1:0] d;
    maxpool_en = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = (i == 0) ? pack_all(10) : (i == 1) ? pack_all(-20) : rand_beat();
      send(d);
      checks++;
      if (out_valid !== 1'b1 || out_data !== expect_bypass(d) || busy !== 1'b0) begin
        failures++;
        $display("FAIL bypass[%0d] got valid=%b data=%h busy=%b want 1 %h 0",
                 i, out_valid, out_data, busy, expect_bypass(d));
      end
    end
    maxpool_en = 1'b1;
    send(rand_beat());
    send(rand_beat());
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL mode_switch_pre busy got=%b want=1", busy);
    end
    maxpool_en = 1'b0;
    d = rand_beat();
    send(d);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b1 || out_data !== expect_bypass(d)) begin
      failures++;
      $display("FAIL mode_switch got busy=%b valid=%b data=%h want 0 1 %h",
               busy, out_valid, out_data, expect_bypass(d));
    end
    maxpool_en = 1'b1;
    for (int k = 0; k < WIN; k++) bt[k] = rand_beat();
    do_window("after_switch");
  endtask

  task automatic test_reset_mid();
    maxpool_en = 1'b1;
    out_ready = 1'b1;
    tick();
    send(rand_beat());
    send(rand_beat());
    out_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_partial got busy=%b valid=%b ready=%b want 0 0 1",
               busy, out_valid, in_ready);
    end
    for (int k = 0; k < WIN; k++) bt[k] = rand_beat();
    for (int k = 0; k < WIN; k++) send(bt[k]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_pending got busy=%b valid=%b ready=%b data=%h want 0 0 1 0",
               busy, out_valid, in_ready, out_data);
    end
    out_ready = 1'b1;
    for (int k = 0; k < WIN; k++) bt[k] = rand_beat();
    do_window("after_reset");
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] exp_q [$];
    int n = 0;
    logic take, drain;
    maxpool_en = 1'b1;
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rand_beat();
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (out_valid !== (exp_q.size() != 0) ||
          (exp_q.size() != 0 && out_data !== exp_q[0]) ||
          in_ready !== (exp_q.size() == 0 || out_ready)) begin
        failures++;
        $display("FAIL b2b cyc=%0d got valid=%b data=%h ready=%b want valid=%b data=%h",
                 cyc, out_valid, out_data, in_ready, exp_q.size() != 0,
                 (exp_q.size() != 0) ? exp_q[0] : '0);
      end
      drain = (exp_q.size() != 0) && out_ready;
      take  = in_valid && (exp_q.size() == 0 || out_ready);
      if (drain) void'(exp_q.pop_front());
      if (take) begin
        bt[n] = in_data;
        n++;
        if (n == WIN) begin
          exp_q.push_back(expect_max());
          n = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random_windows();
    test_backpressure();
    test_flush();
    test_bypass();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxpool_unit.md
MAXPOOL_UNIT -- requirements
Module: maxpool_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, per-channel element width (signed two's complement Qint).
REQ-002 SHALL have parameter CH, default 4, number of parallel channels per beat.
REQ-003 SHALL have parameter WIN, default 4, elements per pooling window; legal range 1..16.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port maxpool_en  input  1  1 = window max mode, 0 = bypass.
REQ-007 SHALL have port flush  input  1  single-cycle pulse that discards any partial window.
REQ-008 SHALL have port in_valid  input  1  input beat valid.
REQ-009 SHALL have port in_ready  output  1  input beat accepted when in_valid and in_ready are both 1.
REQ-010 SHALL have port in_data  input  CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W].
REQ-011 SHALL have port out_valid  output  1  output register holds a result.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-013 SHALL have port out_data  output  CH*DATA_W  per-channel result, same packing as in_data.
REQ-014 SHALL have port busy  output  1  high while a partial window is held (win_cnt != 0).

Function
REQ-015 SHALL drive in_ready = !out_valid || out_ready (combinational; single output register, no skid).
REQ-016 SHALL compare per channel as signed DATA_W values; no widening, no saturation, ties keep the accumulator value.
REQ-017 SHALL, in max mode, load acc directly from in_data on the accepted beat with win_cnt == 0 (no zero seeding), and otherwise set acc = max(acc, in_data) per channel.
REQ-018 SHALL, in max mode, on the accepted beat with win_cnt == WIN-1, write max(acc, in_data) (or in_data when WIN == 1) to out_data, set out_valid, and reset win_cnt to 0; otherwise increment win_cnt.
REQ-019 SHALL present the window result one cycle after the final beat is accepted (latency 1).
REQ-020 SHALL, in bypass mode, copy each accepted beat to out_data with out_valid set one cycle later, and hold win_cnt at 0.
REQ-021 SHALL clear out_valid when out_valid && out_ready, unless a new result loads in the same cycle; a simultaneous drain and load keeps out_valid at 1 with the new data.
REQ-022 SHALL, when maxpool_en is sampled 0 while win_cnt != 0, discard the partial window (win_cnt set to 0) and treat any beat accepted that cycle as bypass.
REQ-023 SHALL give flush priority over an accepted beat: win_cnt is set to 0 and the beat is dropped; out_valid and out_data are unaffected.
REQ-024 SHALL hold acc, win_cnt and out_data unchanged on cycles with no accepted beat.

Reset
REQ-025 SHALL, while rst is 1 at a clock edge, set out_valid=0, out_data=0, acc=0, win_cnt=0 and busy=0, overriding all other inputs.
REQ-026 SHALL drop a partially accumulated window and any undrained result on reset mid-operation.
REQ-027 SHALL drive in_ready=1 in the first cycle after reset is released.

Configuration
REQ-028 SHALL implement macro MAXPOOL_RELU_EN: when defined, each output channel value below 0 is written as 0 in both modes. When undefined, the raw signed result is written.

Verification
REQ-029 WIN=4, CH=1: beats -5,-3,-7,-9 with out_ready=1 -> out_data=-3 one cycle after the 4th beat (0 if MAXPOOL_RELU_EN).
REQ-030 WIN=4: beats 0x7F,0x80,0x01,0x00 -> out_data=0x7F (signed compare, 0x80 = -128 is not the max).
REQ-031 out_ready=0 with result pending -> in_ready=0, 5th beat not accepted and out_data stable; out_ready=1 -> drain and accept the same cycle.
REQ-032 Two beats into a window, then a flush pulse, then beats 1,2,3,4 -> out_data=4; busy=0 right after the flush.
REQ-033 maxpool_en=0, beats 10,-20 -> outputs 10,-20 (-20 becomes 0 with MAXPOOL_RELU_EN), each one cycle after its beat.
REQ-034 rst asserted with win_cnt=2 and out_valid=1 -> next cycle out_valid=0, busy=0, in_ready=1.
